control_ajustes: RTL
====================

Name: control_ajustes

Overview:
- Sequencer that sits directly after the main control-gating stage (enable/reset gating of the front-panel commands).
- Takes the gated command levels (frequency up/down, current up/down, mode, master reset) and performs, per press:
  - synchronisation and debounce;
  - edge detection and priority arbitration;
  - update of the frequency and current setpoint registers, with saturation limits.
- Its outputs drive the frequency generator and the current driver.

Parameters:
- DEB_CYC, 4: consecutive stable cycles needed to accept a new debounced level (≥2).
- FREQ_W, 4: width of the frequency setpoint.
- CORR_W, 4: width of the current setpoint.
- FREQ_MIN, 0 / FREQ_MAX, 15: frequency saturation bounds.
- CORR_MIN, 0 / CORR_MAX, 15: current saturation bounds.
- FREQ_RST, 8 / CORR_RST, 8: setpoint values loaded by reset and by MRst_i.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- aumf_i  in  1  increase-frequency command level
- bajaf_i  in  1  decrease-frequency command level
- aumC_i  in  1  increase-current command level
- bajaC_i  in  1  decrease-current command level
- MODO_i  in  1  mode-toggle command level
- MRst_i  in  1  setpoint-restore command level
- freq_o  out  FREQ_W  frequency setpoint
- corr_o  out  CORR_W  current setpoint
- modo_o  out  1  operating mode
- cambio_o  out  1  one-cycle pulse: a setpoint or the mode changed
- limite_o  out  1  one-cycle pulse: command rejected at a bound
- ocupado_o  out  1  high while FSM is in HOLD

Behaviour:
- Reset (rst=1 at a clock edge), all registered:
  - freq_o=FREQ_RST, corr_o=CORR_RST;
  - modo_o, cambio_o, limite_o, ocupado_o = 0;
  - sync flops, debounced levels and debounce counters cleared;
  - FSM=IDLE.
  - Reset overrides everything and may hit mid-debounce or in HOLD.
- Synchroniser: 2-FF chain per input.
- Debounce, per input:
  - counter increments while the synchronised level differs from the accepted level;
  - counter clears to 0 whenever they match;
  - on reaching DEB_CYC the accepted level flips and the counter clears;
  - glitches shorter than DEB_CYC cycles (after sync) are discarded.
- Press = rising edge of the accepted level (accepted & ~accepted_prev).
- Latency: raw input rising, first sampled high at edge k, produces the setpoint/mode update and the cambio_o or limite_o pulse at edge k+DEB_CYC+2.
- FSM IDLE:
  - if any press is present, execute only the highest-priority one, then go to HOLD;
  - priority: MRst_i > MODO_i > aumf_i > bajaf_i > aumC_i > bajaC_i;
  - simultaneous lower-priority presses are dropped, not queued.
- FSM HOLD:
  - ocupado_o=1; new presses ignored;
  - return to IDLE on the first cycle all six accepted levels are 0;
  - one press means one step, no auto-repeat.
- Execution:
  - aumf: freq_o<FREQ_MAX ? freq_o+1 with cambio_o : unchanged with limite_o.
  - bajaf: freq_o>FREQ_MIN ? freq_o-1 with cambio_o : unchanged with limite_o.
  - aumC / bajaC: same rules on corr_o with CORR_MIN/CORR_MAX.
  - MODO: modo_o toggles, cambio_o.
  - MRst: freq_o=FREQ_RST, corr_o=CORR_RST, modo_o=0; cambio_o always pulses, even if values were already defaults.
- Arithmetic: never wraps; comparisons are unsigned at FREQ_W/CORR_W.
- Pulse rules: cambio_o and limite_o are exclusive and last exactly one cycle.
- Input held high across reset release: it is debounced afresh and counts as a new press.

Test Plan:
- Reset default: rst=1 for 2 cycles -> freq_o=8, corr_o=8, modo_o=0, all pulses 0, ocupado_o=0.
- Latency and single step:
  - aumf_i high from edge k, held 20 cycles -> freq_o=9 at edge k+6, cambio_o high for that single cycle, ocupado_o high until release is debounced;
  - freq_o stays 9 (no repeat).
- Debounce: aumC_i high for 3 cycles then low -> corr_o stays 8, no pulses; 4-cycle-stable pulse -> corr_o=9.
- Saturation:
  - 7 separate bajaf_i presses from 8 -> freq_o=1;
  - 8th press -> 0 with cambio_o;
  - 9th press -> 0 with limite_o=1, cambio_o=0.
  - Same for aumC_i past 15.
- Priority: aumf_i and bajaC_i rise on the same edge -> freq_o 8→9, corr_o unchanged; MRst_i+MODO_i together -> defaults restored, modo_o=0.
- Reset mid-operation:
  - rst during HOLD with aumf_i still high -> defaults restored;
  - after rst release aumf_i is re-debounced -> freq_o=9 at DEB_CYC+2 edges after first post-reset sample.

Source files
------------

// File: rtl/control_ajustes.sv
// control_ajustes: debounces the gated front-panel commands and steps the frequency/current setpoints and the mode.
// Latency: raw command first sampled at edge k updates the setpoint and pulses cambio_o/limite_o at edge k+DEB_CYC+2.
// Backpressure: none; one press executes one step, and presses arriving while in HOLD (ocupado_o=1) are dropped.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   aumf_i / bajaf_i          frequency up / down command levels
//   aumC_i / bajaC_i          current up / down command levels
//   MODO_i                    mode-toggle command level
//   MRst_i                    restore-defaults command level
//   freq_o / corr_o           frequency / current setpoints (saturating)
//   modo_o                    operating mode
//   cambio_o                  one-cycle pulse: a setpoint or the mode changed
//   limite_o                  one-cycle pulse: a step was refused at a bound
//   ocupado_o                 high while waiting for all commands to be released
module control_ajustes #(
   parameter int unsigned DEB_CYC = 4,
   parameter int unsigned FREQ_W  = 4,
   parameter int unsigned CORR_W  = 4,
   parameter logic [FREQ_W-1:0] FREQ_MIN = FREQ_W'(0),
   parameter logic [FREQ_W-1:0] FREQ_MAX = FREQ_W'(15),
   parameter logic [CORR_W-1:0] CORR_MIN = CORR_W'(0),
   parameter logic [CORR_W-1:0] CORR_MAX = CORR_W'(15),
   parameter logic [FREQ_W-1:0] FREQ_RST = FREQ_W'(8),
   parameter logic [CORR_W-1:0] CORR_RST = CORR_W'(8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              aumf_i,
   input  logic              bajaf_i,
   input  logic              aumC_i,
   input  logic              bajaC_i,
   input  logic              MODO_i,
   input  logic              MRst_i,
   output logic [FREQ_W-1:0] freq_o,
   output logic [CORR_W-1:0] corr_o,
   output logic              modo_o,
   output logic              cambio_o,
   output logic              limite_o,
   output logic              ocupado_o
);

   // Command vector bit positions, ordered by priority (bit 0 wins).
   localparam int unsigned NCMD    = 6;
   localparam int unsigned C_MRST  = 0;
   localparam int unsigned C_MODO  = 1;
   localparam int unsigned C_AUMF  = 2;
   localparam int unsigned C_BAJAF = 3;
   localparam int unsigned C_AUMC  = 4;
   localparam int unsigned C_BAJAC = 5;

   localparam int unsigned CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   logic [NCMD-1:0] cmd_raw;

   logic [NCMD-1:0]            sync1_q, sync1_d;
   logic [NCMD-1:0]            sync2_q, sync2_d;
   logic [NCMD-1:0]            acc_q, acc_d;
   logic [NCMD-1:0]            acc_prev_q, acc_prev_d;
   logic [NCMD-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NCMD-1:0]            press;

   state_t            state_q, state_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic [CORR_W-1:0] corr_q, corr_d;
   logic              modo_q, modo_d;
   logic              cambio_q, cambio_d;
   logic              limite_q, limite_d;
   logic              ocupado_q, ocupado_d;

   assign cmd_raw = {bajaC_i, aumC_i, bajaf_i, aumf_i, MODO_i, MRst_i};

   // Synchroniser and debounce. The counter measures how long the
   // synchronised level has disagreed with the accepted level; on the
   // DEB_CYC-th consecutive disagreement the accepted level follows.
   always_comb begin
      sync1_d    = cmd_raw;
      sync2_d    = sync1_q;
      acc_prev_d = acc_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      for (int i = 0; i < NCMD; i++) begin
         if (sync2_q[i] == acc_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            acc_d[i] = ~acc_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign press = acc_q & ~acc_prev_q;

   // Sequencer: IDLE executes the highest-priority press only, then HOLD
   // waits for every accepted level to drop so a held button steps once.
   always_comb begin
      state_d   = state_q;
      freq_d    = freq_q;
      corr_d    = corr_q;
      modo_d    = modo_q;
      cambio_d  = 1'b0;
      limite_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (|press) begin
               state_d = ST_HOLD;
               if (press[C_MRST]) begin
                  // Always reported as a change, even if already at defaults.
                  freq_d   = FREQ_RST;
                  corr_d   = CORR_RST;
                  modo_d   = 1'b0;
                  cambio_d = 1'b1;
               end else if (press[C_MODO]) begin
                  modo_d   = ~modo_q;
                  cambio_d = 1'b1;
               end else if (press[C_AUMF]) begin
                  if (freq_q < FREQ_MAX) begin
                     freq_d   = freq_q + FREQ_W'(1);
                     cambio_d = 1'b1;
                  end else begin
                     limite_d = 1'b1;
                  end
               end else if (press[C_BAJAF]) begin
                  if (freq_q > FREQ_MIN) begin
                     freq_d   = freq_q - FREQ_W'(1);
                     cambio_d = 1'b1;
                  end else begin
                     limite_d = 1'b1;
                  end
               end else if (press[C_AUMC]) begin
                  if (corr_q < CORR_MAX) begin
                     corr_d   = corr_q + CORR_W'(1);
                     cambio_d = 1'b1;
                  end else begin
                     limite_d = 1'b1;
                  end
               end else begin
                  // Only bajaC can remain here.
                  if (corr_q > CORR_MIN) begin
                     corr_d   = corr_q - CORR_W'(1);
                     cambio_d = 1'b1;
                  end else begin
                     limite_d = 1'b1;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (acc_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ocupado_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         acc_q      <= '0;
         acc_prev_q <= '0;
         cnt_q      <= '0;
         state_q    <= ST_IDLE;
         freq_q     <= FREQ_RST;
         corr_q     <= CORR_RST;
         modo_q     <= 1'b0;
         cambio_q   <= 1'b0;
         limite_q   <= 1'b0;
         ocupado_q  <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         acc_q      <= acc_d;
         acc_prev_q <= acc_prev_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         freq_q     <= freq_d;
         corr_q     <= corr_d;
         modo_q     <= modo_d;
         cambio_q   <= cambio_d;
         limite_q   <= limite_d;
         ocupado_q  <= ocupado_d;
      end
   end

   assign freq_o    = freq_q;
   assign corr_o    = corr_q;
   assign modo_o    = modo_q;
   assign cambio_o  = cambio_q;
   assign limite_o  = limite_q;
   assign ocupado_o = ocupado_q;

endmodule
